buf_byte_sender: RTL and testbench

BUF_BYTE_SENDER -- requirements
Module: buf_byte_sender

---
 rtl/tsc_pkg.sv | 31 +++
 rtl/word_fifo.sv | 53 +++++
 rtl/buf_byte_sender.sv | 160 ++++++++++++++++
 tb/tb_buf_byte_sender.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared constants, FSM state type and byte-select helper for the timestamp capture/sender blocks.
// Pure declarations: no latency, no flow control.
package tsc_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_CHECKSUM
    } tx_state_e;

    // Index 0 selects the most significant byte so words go out MSB-first.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with extra-bit pointers; read data is the combinational head entry.
// Push is ignored when full, pop is ignored when empty; o_full_nxt gives next-cycle fullness.
module word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_full_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_wr_nxt;
    logic [AW:0]      w_rd_nxt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_wr_nxt  = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
    assign w_rd_nxt  = r_rd_ptr + {{AW{1'b0}}, w_pop_ok};
    assign o_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        end
    end

endmodule

// File: rtl/buf_byte_sender.sv
// Frames buffered timestamp words as SYNC, data bytes MSB-first, XOR checksum; header 2 cycles after first push.
// word_ready is registered !full; tx_byte holds while tx_ready is low; back-to-back words within a frame have no bubbles.
module buf_byte_sender
    import tsc_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [BYTE_W-1:0] SYNC_BYTE  = SYNC_BYTE_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              frame_done,
    output logic              busy
);

    tx_state_e         r_state;
    logic [WORD_W-1:0] r_word;
    logic              r_last;
    logic [1:0]        r_idx;
    logic [BYTE_W-1:0] r_csum;
    logic [BYTE_W-1:0] r_tx_byte;
    logic              r_tx_valid;
    logic              r_frame_done;
    logic              r_word_ready;

    logic              w_push;
    logic              w_pop;
    logic [WORD_W:0]   w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_full_nxt;
    logic              w_xfer;

    assign w_push     = word_valid && r_word_ready;
    assign w_xfer     = r_tx_valid && tx_ready;
    assign word_ready = r_word_ready;
    assign tx_byte    = r_tx_byte;
    assign tx_valid   = r_tx_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != ST_IDLE) || !w_empty;

    word_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat ({word_last, word_data}),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_full_nxt (w_full_nxt)
    );

    // Pop exactly when the FSM below loads a new word into r_word.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_HEADER: w_pop = w_xfer;
            ST_DATA: begin
                if (r_tx_valid) begin
                    w_pop = w_xfer && (r_idx == 2'd3) && !r_last && !w_empty;
                end else begin
                    w_pop = !w_empty;
                end
            end
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= !w_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_last       <= 1'b0;
            r_idx        <= 2'd0;
            r_csum       <= '0;
            r_tx_byte    <= '0;
            r_tx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state    <= ST_HEADER;
                        r_csum     <= '0;
                        r_tx_byte  <= SYNC_BYTE;
                        r_tx_valid <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (w_xfer) begin
                        r_state    <= ST_DATA;
                        r_word     <= w_head[WORD_W-1:0];
                        r_last     <= w_head[WORD_W];
                        r_idx      <= 2'd0;
                        r_tx_byte  <= word_byte(w_head[WORD_W-1:0], 2'd0);
                        r_tx_valid <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_tx_valid) begin
                        if (w_xfer) begin
                            r_csum <= r_csum ^ r_tx_byte;
                            if (r_idx == 2'd3) begin
                                if (r_last) begin
                                    r_state   <= ST_CHECKSUM;
                                    r_tx_byte <= r_csum ^ r_tx_byte;
                                end else if (!w_empty) begin
                                    r_word    <= w_head[WORD_W-1:0];
                                    r_last    <= w_head[WORD_W];
                                    r_idx     <= 2'd0;
                                    r_tx_byte <= word_byte(w_head[WORD_W-1:0], 2'd0);
                                end else begin
                                    r_tx_valid <= 1'b0;
                                end
                            end else begin
                                r_idx     <= r_idx + 2'd1;
                                r_tx_byte <= word_byte(r_word, r_idx + 2'd1);
                            end
                        end
                    end else if (!w_empty) begin
                        // Starved mid-frame: resume as soon as the next word lands.
                        r_word     <= w_head[WORD_W-1:0];
                        r_last     <= w_head[WORD_W];
                        r_idx      <= 2'd0;
                        r_tx_byte  <= word_byte(w_head[WORD_W-1:0], 2'd0);
                        r_tx_valid <= 1'b1;
                    end
                end
                ST_CHECKSUM: begin
                    if (w_xfer) begin
                        r_state      <= ST_IDLE;
                        r_tx_valid   <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buf_byte_sender.sv
// Directed bench for buf_byte_sender: a scoreboard queue is filled as words are driven and drained by a byte monitor.
// Covers reset values, header latency, multi-word frames, stalls, FIFO-full backpressure and mid-frame reset.
module tb_buf_byte_sender;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_last;
    logic        word_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_done;
    logic        busy;

    always #5 clk = ~clk;

    buf_byte_sender dut (
        .clk        (clk),
        .reset      (reset),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_last  (word_last),
        .word_ready (word_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] b;
        bit         hdr;
        bit         csm;
    } exp_t;

    localparam logic [7:0] SYNC = 8'hA5;

    exp_t       sb[$];
    exp_t       m_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         rx_count = 0;
    int         fd_count = 0;
    int         frames_exp = 0;
    int         hdr_cyc = 0;
    int         csum_cyc = 0;
    bit         fd_pend = 1'b0;
    bit         m_in_frame = 1'b0;
    logic [7:0] m_csum = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            chk("frame_done", {31'd0, frame_done}, {31'd0, fd_pend});
            if (frame_done) fd_count++;
            fd_pend = 1'b0;
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    m_e = sb.pop_front();
                    chk("tx_byte", {24'd0, tx_byte}, {24'd0, m_e.b});
                    if (m_e.hdr) hdr_cyc = cyc;
                    if (m_e.csm) begin
                        csum_cyc = cyc;
                        fd_pend  = 1'b1;
                    end
                end
                rx_count++;
            end
        end else begin
            fd_pend = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] data, input logic last);
        logic [7:0] b;
        bit         acc;
        if (!m_in_frame) begin
            sb.push_back('{SYNC, 1'b1, 1'b0});
            m_csum     = 8'h00;
            m_in_frame = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            b = data[31-8*i -: 8];
            sb.push_back('{b, 1'b0, 1'b0});
            m_csum ^= b;
        end
        if (last) begin
            sb.push_back('{m_csum, 1'b0, 1'b1});
            m_in_frame = 1'b0;
            frames_exp++;
        end
        word_data  = data;
        word_last  = last;
        word_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = word_ready;
            step();
        end
        word_valid = 1'b0;
        chk("push_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 2000; n++) begin
            step();
            if (sb.size() == 0 && !busy) break;
        end
        step();
        step();
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_frames"}, fd_count, frames_exp);
    endtask

    task automatic wait_rx(input int target);
        for (int n = 0; n < 500; n++) begin
            step();
            if (rx_count >= target) break;
        end
        chk("wait_rx_reached", {31'd0, rx_count >= target}, 32'd1);
    endtask

    int         r0;
    logic [7:0] cap_b;

    initial begin
        reset      = 1'b1;
        word_data  = '0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        tx_ready   = 1'b1;
        repeat (3) step();

        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_word_ready", {31'd0, word_ready}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", {31'd0, word_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, word_ready}, 32'd1);
        step();

        // Single-word frame and header latency.
        r0 = rx_count;
        push_word(32'h11223344, 1'b1);
        @(negedge clk);
        chk("lat_cycle1_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {31'd0, tx_valid}, 32'd1);
        chk("lat_cycle2_byte", {24'd0, tx_byte}, {24'd0, SYNC});
        drain("one_word");
        chk("one_word_len", rx_count - r0, 6);

        // Two-word frame with no bubbles.
        r0 = rx_count;
        push_word(32'hDEADBEEF, 1'b0);
        push_word(32'h00000001, 1'b1);
        drain("two_word");
        chk("two_word_len", rx_count - r0, 10);
        chk("two_word_span", csum_cyc - hdr_cyc, 9);

        // Stall mid-word.
        r0 = rx_count;
        push_word(32'h01020304, 1'b0);
        push_word(32'h05060708, 1'b1);
        wait_rx(r0 + 3);
        tx_ready = 1'b0;
        @(negedge clk);
        cap_b = tx_byte;
        chk("stall_valid_at_cap", {31'd0, tx_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_byte", {24'd0, tx_byte}, {24'd0, cap_b});
            chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        end
        step();
        tx_ready = 1'b1;
        drain("stall");
        chk("stall_len", rx_count - r0, 10);

        // FIFO-full backpressure.
        r0 = rx_count;
        tx_ready = 1'b0;
        push_word(32'hA0A1A2A3, 1'b0);
        push_word(32'hB0B1B2B3, 1'b0);
        push_word(32'hC0C1C2C3, 1'b0);
        push_word(32'hD0D1D2D3, 1'b0);
        @(negedge clk);
        chk("full_ready_low", {31'd0, word_ready}, 32'd0);
        step();
        word_data  = 32'hE0E1E2E3;
        word_last  = 1'b1;
        word_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold", {31'd0, word_ready}, 32'd0);
        end
        step();
        tx_ready = 1'b1;
        push_word(32'hE0E1E2E3, 1'b1);
        drain("full");
        chk("full_len", rx_count - r0, 22);

        // Reset during the second word of a three-word frame.
        r0 = rx_count;
        push_word(32'h10203040, 1'b0);
        push_word(32'h50607080, 1'b0);
        push_word(32'h90A0B0C0, 1'b1);
        wait_rx(r0 + 7);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("mid_rst_word_ready", {31'd0, word_ready}, 32'd0);
        chk("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        m_in_frame = 1'b0;
        frames_exp--;
        step();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_ready_back", {31'd0, word_ready}, 32'd1);
        step();
        r0 = rx_count;
        push_word(32'hCAFEF00D, 1'b1);
        drain("post_rst");
        chk("post_rst_len", rx_count - r0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
